// File: rtl/fpu_pkg.sv
// Opcodes, FSM states and per-issue tag shared by the FPU arbiter slice.
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ISSUE,
        DRAIN,
        DIV_WAIT
    } state_e;

    typedef struct packed {
        logic valid;
        logic requester;
    } tag_t;

endpackage

// File: rtl/fpu_tag_pipe.sv
// Fixed-depth tag shift register that follows add/sub/mul through the FPU pipeline.
module fpu_tag_pipe
    import fpu_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_head,
    output logic nonempty
);

    tag_t pipe [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tag_head = pipe[DEPTH-1];

    always_comb begin
        nonempty = 1'b0;
        for (int i = 0; i < DEPTH; i++) nonempty = nonempty | pipe[i].valid;
    end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// Round-robin sharing of one FPU between two requesters; pipelined add/sub/mul,
// div serialised through a drain/wait sequence.
module fpu_rr_arbiter
    import fpu_pkg::*;
#(
    parameter int FPU_LATENCY = 3,
    parameter int DIV_LATENCY = 12
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req0Valid,
    output logic        Req0Ready,
    input  logic [31:0] Req0Operand1,
    input  logic [31:0] Req0Operand2,
    input  logic [1:0]  Req0Operation,
    input  logic        Req1Valid,
    output logic        Req1Ready,
    input  logic [31:0] Req1Operand1,
    input  logic [31:0] Req1Operand2,
    input  logic [1:0]  Req1Operation,
    output logic [31:0] FpuOperand1,
    output logic [31:0] FpuOperand2,
    output logic [1:0]  FpuOperation,
    input  logic [31:0] FpuResult,
    output logic        Rsp0Valid,
    output logic        Rsp1Valid,
    output logic [31:0] RspResult,
    output logic        Busy
);

    localparam int CW = $clog2(DIV_LATENCY + 1);

    state_e        state, state_nx;
    logic          last_grant;
    logic          hold_vld, hold_req;
    logic          div_owner;
    logic [CW-1:0] div_cnt;
    logic          div_done;

    logic          sel, sel_vld, sel_div, grant;
    logic [1:0]    sel_op;
    tag_t          tag_in, tag_head;
    logic          tag_busy;

    // A div parked in DRAIN keeps its grant so it cannot be overtaken on return.
    always_comb begin
        sel = ~last_grant;
        if (hold_vld)                    sel = hold_req;
        else if (Req0Valid && !Req1Valid) sel = 1'b0;
        else if (Req1Valid && !Req0Valid) sel = 1'b1;
    end

    assign sel_vld  = sel ? Req1Valid : Req0Valid;
    assign sel_op   = sel ? Req1Operation : Req0Operation;
    assign sel_div  = (sel_op == OP_DIV);
    assign div_done = (state == DIV_WAIT) && (div_cnt == CW'(DIV_LATENCY - 1));

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        case (state)
            ISSUE: begin
                if (sel_vld) begin
                    if (sel_div && tag_busy) begin
                        state_nx = DRAIN;
                    end else begin
                        grant = 1'b1;
                        if (sel_div) state_nx = DIV_WAIT;
                    end
                end
            end
            DRAIN:    if (!tag_busy) state_nx = ISSUE;
            DIV_WAIT: if (div_done)  state_nx = ISSUE;
            default:  state_nx = ISSUE;
        endcase
    end

    assign Req0Ready = grant & ~sel;
    assign Req1Ready = grant & sel;

    assign tag_in.valid     = grant & ~sel_div;
    assign tag_in.requester = sel;

    fpu_tag_pipe #(.DEPTH(FPU_LATENCY)) u_tag_pipe (
        .clk      (CLK),
        .rst      (RST),
        .tag_in   (tag_in),
        .tag_head (tag_head),
        .nonempty (tag_busy)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ISSUE;
            last_grant   <= 1'b1;
            hold_vld     <= 1'b0;
            hold_req     <= 1'b0;
            div_owner    <= 1'b0;
            div_cnt      <= '0;
            FpuOperand1  <= '0;
            FpuOperand2  <= '0;
            FpuOperation <= '0;
            Rsp0Valid    <= 1'b0;
            Rsp1Valid    <= 1'b0;
            RspResult    <= '0;
        end else begin
            state <= state_nx;

            if (grant) begin
                last_grant   <= sel;
                FpuOperand1  <= sel ? Req1Operand1 : Req0Operand1;
                FpuOperand2  <= sel ? Req1Operand2 : Req0Operand2;
                FpuOperation <= sel_op;
                if (sel_div) div_owner <= sel;
            end

            if (grant) begin
                hold_vld <= 1'b0;
            end else if (state == ISSUE && state_nx == DRAIN) begin
                hold_vld <= 1'b1;
                hold_req <= sel;
            end

            if (state == DIV_WAIT && !div_done) div_cnt <= div_cnt + 1'b1;
            else                                div_cnt <= '0;

            // Pipeline retire and div completion never coincide: div waits for an empty pipe.
            Rsp0Valid <= 1'b0;
            Rsp1Valid <= 1'b0;
            if (tag_head.valid) begin
                RspResult <= FpuResult;
                Rsp0Valid <= ~tag_head.requester;
                Rsp1Valid <= tag_head.requester;
            end else if (div_done) begin
                RspResult <= FpuResult;
                Rsp0Valid <= ~div_owner;
                Rsp1Valid <= div_owner;
            end
        end
    end

    assign Busy = (state != ISSUE) | tag_busy | Rsp0Valid | Rsp1Valid;

endmodule
